// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - Program-load handshake and single-issue pipeline sequencer.
// Optional performance counters are enabled with `define PIPE_PERF_COUNT_EN.
module pipe_sequencer #(
   parameter logic [31:0] PC_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        aa_recieved,
   input  logic        load_done,
   input  logic        aa_sent,
   input  logic [31:0] d_npc,
   input  logic [4:0]  de_wait_time,
   input  logic        de_stop,
   input  logic        e_uart_state,
   output logic [2:0]  mode,
   output logic [2:0]  pipe,
   output logic [31:0] pc,
   output logic [1:0]  fd_update,
   output logic [1:0]  de_update,
   output logic [1:0]  ew_update,
   output logic        e_start,
   output logic        halted
`ifdef PIPE_PERF_COUNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retired_cnt
`endif
);

   typedef enum logic [2:0] {
      MODE_STALL = 3'd0,
      MODE_LOAD  = 3'd1,
      MODE_EXEC  = 3'd2
   } mode_e;

   typedef enum logic [2:0] {
      P_FETCH    = 3'd0,
      P_DECODE   = 3'd1,
      P_EXECUTE  = 3'd2,
      P_WRITEREG = 3'd3,
      P_STOP     = 3'd4
   } pipe_e;

   mode_e       mode_q, mode_d;
   pipe_e       pipe_q, pipe_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  latency_q, latency_d;
   logic [4:0]  wait_q, wait_d;
   logic        e_start_q, e_start_d;
   logic        in_exec;

   assign in_exec = (mode_q == MODE_EXEC);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mode_q    <= MODE_STALL;
         pipe_q    <= P_FETCH;
         pc_q      <= PC_RESET;
         latency_q <= 5'd0;
         wait_q    <= 5'd0;
         e_start_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         pipe_q    <= pipe_d;
         pc_q      <= pc_d;
         latency_q <= latency_d;
         wait_q    <= wait_d;
         e_start_q <= e_start_d;
      end
   end

   always_comb begin
      mode_d    = mode_q;
      pipe_d    = pipe_q;
      pc_d      = pc_q;
      latency_d = latency_q;
      wait_d    = wait_q;
      e_start_d = 1'b0;

      case (mode_q)
         MODE_STALL: if (aa_recieved) mode_d = MODE_LOAD;
         MODE_LOAD:  if (load_done && aa_sent) mode_d = MODE_EXEC;
         default:    mode_d = mode_q;
      endcase

      if (in_exec) begin
         case (pipe_q)
            P_FETCH:  pipe_d = P_DECODE;
            P_DECODE: begin
               pipe_d    = P_EXECUTE;
               pc_d      = d_npc;
               e_start_d = 1'b1;
               wait_d    = de_wait_time;
               latency_d = 5'd0;
            end
            P_EXECUTE: begin
               // Latency freezes at the latched wait while the UART is busy.
               if (latency_q < wait_q)
                  latency_d = latency_q + 5'd1;
               else if (!e_uart_state)
                  pipe_d = P_WRITEREG;
            end
            P_WRITEREG: pipe_d = de_stop ? P_STOP : P_FETCH;
            P_STOP:     pipe_d = P_STOP;
            default:    pipe_d = P_FETCH;
         endcase
      end else begin
         pipe_d = P_FETCH;
      end
   end

   assign mode      = mode_q;
   assign pipe      = pipe_q;
   assign pc        = pc_q;
   assign e_start   = e_start_q;
   assign halted    = (pipe_q == P_STOP);
   assign fd_update = (in_exec && pipe_q == P_FETCH)  ? 2'b01 : 2'b00;
   assign de_update = (in_exec && pipe_q == P_DECODE) ? 2'b01 : 2'b00;
   assign ew_update = !in_exec ? 2'b10 :
                      (pipe_q == P_WRITEREG) ? 2'b01 : 2'b00;

`ifdef PIPE_PERF_COUNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] retired_cnt_q, retired_cnt_d;

   always_comb begin
      cycle_cnt_d   = cycle_cnt_q;
      retired_cnt_d = retired_cnt_q;
      if (in_exec && pipe_q != P_STOP) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (in_exec && pipe_q == P_WRITEREG) retired_cnt_d = retired_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_cnt_q   <= 32'd0;
         retired_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - Self-checking bench for pipe_sequencer.
module tb_pipe_sequencer;

   localparam logic [31:0] PC_RST = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rstn;
   logic        aa_recieved, load_done, aa_sent;
   logic [31:0] d_npc;
   logic [4:0]  de_wait_time;
   logic        de_stop, e_uart_state;
   logic [2:0]  mode, pipe;
   logic [31:0] pc;
   logic [1:0]  fd_update, de_update, ew_update;
   logic        e_start, halted;
`ifdef PIPE_PERF_COUNT_EN
   logic [31:0] cycle_cnt, retired_cnt;
`endif

   pipe_sequencer #(.PC_RESET(PC_RST)) dut (
      .clk(clk), .rstn(rstn), .aa_recieved(aa_recieved), .load_done(load_done),
      .aa_sent(aa_sent), .d_npc(d_npc), .de_wait_time(de_wait_time),
      .de_stop(de_stop), .e_uart_state(e_uart_state), .mode(mode), .pipe(pipe),
      .pc(pc), .fd_update(fd_update), .de_update(de_update), .ew_update(ew_update),
      .e_start(e_start), .halted(halted)
`ifdef PIPE_PERF_COUNT_EN
      , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int retired = 0;
   int exec_cycles = 0;
   logic [31:0] last_npc;

   typedef struct {
      int          w;
      int          w_late;
      int          u;
      logic [31:0] npc;
      int          exp_len;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mode"}, 32'(mode), 32'd0);
      chk({tag, "_pipe"}, 32'(pipe), 32'd0);
      chk({tag, "_pc"}, pc, PC_RST);
      chk({tag, "_estart"}, 32'(e_start), 32'd0);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
      chk({tag, "_fd"}, 32'(fd_update), 32'd0);
      chk({tag, "_de"}, 32'(de_update), 32'd0);
      chk({tag, "_ew"}, 32'(ew_update), 32'd2);
   endtask

   // Execute time per the sequencing rules: wait+1 cycles plus any UART-busy stretch.
   function automatic int model_exec_len(input int w, input int u);
      return w + 1 + u;
   endfunction

   // Drives one instruction from FETCH; w_late < 0 means random de_wait_time after latch.
   task automatic run_instr(input int w, input int w_late, input int u,
                            input logic [31:0] npc, input logic stop, input int exp_len);
      chk("fetch_pipe", 32'(pipe), 32'd0);
      chk("fetch_fd", 32'(fd_update), 32'd1);
      chk("fetch_mode", 32'(mode), 32'd2);
      d_npc = npc;
      de_wait_time = 5'(w);
      de_stop = 1'($urandom_range(0, 1));
      e_uart_state = 1'($urandom_range(0, 1));
      step();
      chk("decode_pipe", 32'(pipe), 32'd1);
      chk("decode_de", 32'(de_update), 32'd1);
      chk("decode_estart", 32'(e_start), 32'd0);
      e_uart_state = 1'($urandom_range(0, 1));
      step();
      for (int k = 0; k < exp_len; k++) begin
         chk("exec_pipe", 32'(pipe), 32'd2);
         chk("exec_estart", 32'(e_start), (k == 0) ? 32'd1 : 32'd0);
         chk("exec_pc", pc, npc);
         chk("exec_ew", 32'(ew_update), 32'd0);
         de_wait_time = (w_late < 0) ? 5'($urandom_range(0, 31)) : 5'(w_late);
         d_npc = $urandom;
         de_stop = 1'($urandom_range(0, 1));
         if (k < w) e_uart_state = 1'($urandom_range(0, 1));
         else       e_uart_state = (k < w + u) ? 1'b1 : 1'b0;
         step();
      end
      chk("wr_pipe", 32'(pipe), 32'd3);
      chk("wr_ew", 32'(ew_update), 32'd1);
      chk("wr_fd", 32'(fd_update), 32'd0);
      de_stop = stop;
      e_uart_state = 1'b0;
      step();
      retired++;
      exec_cycles += exp_len + 3;
      last_npc = npc;
      chk("after_wr_pipe", 32'(pipe), stop ? 32'd4 : 32'd0);
      de_stop = 1'b0;
   endtask

   initial begin
      vecs[0] = '{w: 0,  w_late: 0,  u: 0, npc: 32'h0000_0004, exp_len: 1};
      vecs[1] = '{w: 5,  w_late: 1,  u: 0, npc: 32'h0000_0008, exp_len: 6};
      vecs[2] = '{w: 2,  w_late: 9,  u: 4, npc: 32'h0000_000C, exp_len: 7};
      vecs[3] = '{w: 31, w_late: 0,  u: 0, npc: 32'hFFFF_FFFC, exp_len: 32};
      vecs[4] = '{w: 0,  w_late: 31, u: 3, npc: 32'h1234_5678, exp_len: 4};
      vecs[5] = '{w: 7,  w_late: -1, u: 2, npc: 32'h0000_0040, exp_len: 10};

      rstn = 1'b0;
      aa_recieved = 1'b0; load_done = 1'b0; aa_sent = 1'b0;
      d_npc = 32'h0; de_wait_time = 5'd0; de_stop = 1'b0; e_uart_state = 1'b0;
      last_npc = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");

      rstn = 1'b1;
      step();
      chk("stall_idle", 32'(mode), 32'd0);
      aa_recieved = 1'b1;
      step();
      chk("to_load", 32'(mode), 32'd1);
      aa_recieved = 1'b0;
      aa_sent = 1'b1;
      step();
      chk("load_sent_only", 32'(mode), 32'd1);
      aa_sent = 1'b0;
      load_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         aa_recieved = 1'($urandom_range(0, 1));
         step();
         chk("load_done_only", 32'(mode), 32'd1);
         chk("load_pipe", 32'(pipe), 32'd0);
         chk("load_ew", 32'(ew_update), 32'd2);
      end
      aa_recieved = 1'b0;
      aa_sent = 1'b1;
      step();
      chk("to_exec", 32'(mode), 32'd2);
      load_done = 1'b0;
      aa_sent = 1'b0;

      for (int i = 0; i < 6; i++)
         run_instr(vecs[i].w, vecs[i].w_late, vecs[i].u, vecs[i].npc, 1'b0, vecs[i].exp_len);

      for (int i = 0; i < 15; i++) begin
         int w, u;
         w = $urandom_range(0, 31);
         u = $urandom_range(0, 5);
         aa_recieved = 1'($urandom_range(0, 1));
         run_instr(w, -1, u, $urandom, 1'b0, model_exec_len(w, u));
      end
      aa_recieved = 1'b0;

      run_instr(3, 0, 1, 32'hCAFE_0000, 1'b1, model_exec_len(3, 1));
      for (int i = 0; i < 20; i++) begin
         aa_recieved  = 1'($urandom_range(0, 1));
         load_done    = 1'($urandom_range(0, 1));
         aa_sent      = 1'($urandom_range(0, 1));
         d_npc        = $urandom;
         de_wait_time = 5'($urandom_range(0, 31));
         de_stop      = 1'($urandom_range(0, 1));
         e_uart_state = 1'($urandom_range(0, 1));
         step();
         chk("stop_pipe", 32'(pipe), 32'd4);
         chk("stop_halted", 32'(halted), 32'd1);
         chk("stop_pc", pc, last_npc);
         chk("stop_upd", {26'd0, fd_update, de_update, ew_update}, 32'd0);
         chk("stop_estart", 32'(e_start), 32'd0);
         chk("stop_mode", 32'(mode), 32'd2);
      end
`ifdef PIPE_PERF_COUNT_EN
      chk("retired_cnt", retired_cnt, 32'(retired));
      chk("cycle_cnt", cycle_cnt, 32'(exec_cycles));
`endif

      // Reset between clock edges in the middle of EXECUTE.
      aa_recieved = 1'b0; load_done = 1'b0; aa_sent = 1'b0;
      de_stop = 1'b0; e_uart_state = 1'b0;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      aa_recieved = 1'b1;
      step();
      aa_recieved = 1'b0;
      load_done = 1'b1;
      aa_sent = 1'b1;
      step();
      load_done = 1'b0;
      aa_sent = 1'b0;
      chk("re_exec", 32'(mode), 32'd2);
      d_npc = 32'h0000_ABC0;
      de_wait_time = 5'd10;
      step();
      step();
      chk("mid_exec_pipe", 32'(pipe), 32'd2);
      step();
      #4;
      rstn = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("post_rst_estart", 32'(e_start), 32'd0);
         chk("post_rst_mode", 32'(mode), 32'd0);
         chk("post_rst_pipe", 32'(pipe), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
- REQ-001 SHALL have parameter PC_RESET, default 32'h0: pc value loaded on reset.
- REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
- REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
- REQ-004 SHALL have port aa_recieved  input  1  host handshake byte received; requests program load.
- REQ-005 SHALL have port load_done  input  1  fetch-side program load complete.
- REQ-006 SHALL have port aa_sent  input  1  acknowledge byte transmitted to host.
- REQ-007 SHALL have port d_npc  input  32  next pc from decode.
- REQ-008 SHALL have port de_wait_time  input  5  execute latency of the instruction in the decode/execute register.
- REQ-009 SHALL have port de_stop  input  1  the instruction in the decode/execute register is a halt.
- REQ-010 SHALL have port e_uart_state  input  1  execute UART busy (1 = busy).
- REQ-011 SHALL have port mode  output  3  0 STALL, 1 LOAD, 2 EXEC.
- REQ-012 SHALL have port pipe  output  3  0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEREG, 4 STOP.
- REQ-013 SHALL have port pc  output  32  current fetch address.
- REQ-014 SHALL have ports fd_update, de_update, ew_update  output  2 each  pipeline-register control: 00 hold, 01 load, 10 flush.
- REQ-015 SHALL have port e_start  output  1  one-cycle execute start pulse.
- REQ-016 SHALL have port halted  output  1  high while pipe == STOP.

Function
- REQ-017 SHALL transition STALL->LOAD on aa_recieved=1; LOAD->EXEC when load_done=1 and aa_sent=1 in the same cycle; EXEC is left only by reset.
- REQ-018 SHALL ignore aa_recieved outside STALL, and hold LOAD while only one of load_done, aa_sent is high.
- REQ-019 SHALL hold pipe at FETCH while mode != EXEC.
- REQ-020 SHALL, in EXEC, sequence FETCH->DECODE->EXECUTE->WRITEREG->FETCH, one cycle each except EXECUTE; WRITEREG goes to STOP instead when de_stop=1.
- REQ-021 SHALL, on the DECODE->EXECUTE edge, load pc <= d_npc, set e_start=1, latch de_wait_time into an internal wait register, and clear the 5-bit latency counter.
- REQ-022 SHALL drive e_start=1 for exactly the first EXECUTE cycle and 0 otherwise.
- REQ-023 SHALL, in EXECUTE, increment latency while latency < latched wait, and exit to WRITEREG when latency == latched wait and e_uart_state=0; EXECUTE lasts latched wait + 1 cycles minimum, so an instruction takes wait + 4 cycles.
- REQ-024 SHALL hold EXECUTE with latency frozen while e_uart_state=1 at latency == latched wait.
- REQ-025 SHALL ignore changes of de_wait_time after the latch cycle.
- REQ-026 SHALL drive fd_update=01 when mode==EXEC and pipe==FETCH, else 00.
- REQ-027 SHALL drive de_update=01 when mode==EXEC and pipe==DECODE, else 00.
- REQ-028 SHALL drive ew_update=01 when mode==EXEC and pipe==WRITEREG, 10 when mode != EXEC, else 00.
- REQ-029 SHALL remain in STOP with pc frozen and all update outputs 00 until reset.

Reset
- REQ-030 SHALL, on rstn=0, immediately and asynchronously set mode=STALL, pipe=FETCH, pc=PC_RESET, latency=0, wait register=0, e_start=0, halted=0.
- REQ-031 SHALL abandon any in-flight instruction when reset is asserted mid-EXECUTE, with no further e_start after release.

Configuration
- REQ-032 SHALL, with PIPE_PERF_COUNT_EN defined, add outputs cycle_cnt (32) counting EXEC-mode cycles before STOP and retired_cnt (32) incremented on each WRITEREG cycle, both reset to 0 and wrapping modulo 2^32.
- REQ-033 SHALL, without PIPE_PERF_COUNT_EN, omit both counters and ports, with all other behaviour unchanged.

Verification
- REQ-034 Reset, then pulse aa_recieved; then load_done=1 with aa_sent=0 for 3 cycles, then aa_sent=1 -> mode 0->1, stays 1, then 2 one cycle after both are high.
- REQ-035 EXEC, de_wait_time=0, d_npc=4 -> pipe 0,1,2,3,0; pc=4 from the first EXECUTE cycle; e_start high one cycle.
- REQ-036 de_wait_time=5, changed to 1 during EXECUTE -> EXECUTE lasts 6 cycles, latency 0..5.
- REQ-037 de_wait_time=2, e_uart_state=1 for 4 extra cycles -> EXECUTE lasts 7 cycles, then WRITEREG.
- REQ-038 de_stop=1 at WRITEREG -> pipe=4, halted=1, pc and updates frozen for 20 cycles; with PIPE_PERF_COUNT_EN, retired_cnt equals instructions executed.
- REQ-039 rstn low mid-EXECUTE between clock edges -> outputs reach reset values before the next edge.
